// File: rtl/trap_ctrl_if.sv
// Trap sequencer bus: exception/mret requests and CSR inputs from the pipeline,
// save/flush/redirect commands back out. master = pipeline side, slave = trap_ctrl.
interface trap_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             exc_id_valid_i;
  logic [4:0]       exc_id_cause_i;
  logic             exc_ex_valid_i;
  logic [4:0]       exc_ex_cause_i;
  logic             mret_ex_i;
  logic [31:0]      mtvec_i;
  logic [31:0]      mepc_i;
  logic             save_pc_id_o;
  logic             save_pc_ex_o;
  logic [4:0]       exception_cause_o;
  logic             flush_if_o;
  logic             flush_id_o;
  logic             flush_ex_o;
  logic             redirect_valid_o;
  logic [31:0]      redirect_addr_o;
  logic             redirect_ready_i;
  logic             busy_o;
  logic             lockup_o;
  logic [CNT_W-1:0] trap_count_o;

  modport master (
    output exc_id_valid_i, exc_id_cause_i, exc_ex_valid_i, exc_ex_cause_i,
           mret_ex_i, mtvec_i, mepc_i, redirect_ready_i,
    input  save_pc_id_o, save_pc_ex_o, exception_cause_o, flush_if_o,
           flush_id_o, flush_ex_o, redirect_valid_o, redirect_addr_o,
           busy_o, lockup_o, trap_count_o
  );

  modport slave (
    input  exc_id_valid_i, exc_id_cause_i, exc_ex_valid_i, exc_ex_cause_i,
           mret_ex_i, mtvec_i, mepc_i, redirect_ready_i,
    output save_pc_id_o, save_pc_ex_o, exception_cause_o, flush_if_o,
           flush_id_o, flush_ex_o, redirect_valid_o, redirect_addr_o,
           busy_o, lockup_o, trap_count_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: arbitrates EX exception > mret > ID exception, commands CSR saves,
// flushes stages and holds a fetch redirect. Optional nested-trap lockup via TRAP_LOCKUP_EN.
module trap_ctrl #(
  parameter int CNT_W = 16
) (
  input logic       clk_i,
  input logic       rst_n_i,
  trap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1
`ifdef TRAP_LOCKUP_EN
    ,LOCKUP  = 2'd2
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] count_q;
  logic             count_inc;
  logic             save_id, save_ex;
  logic [4:0]       cause;
  logic             fl_if, fl_id, fl_ex;
  logic             is_exc;
`ifdef TRAP_LOCKUP_EN
  logic             handler_q, handler_d;
`endif

  // Target alignment discards the low bits of mtvec/mepc by construction.
  logic unused_bits;
  assign unused_bits = ^{bus.mtvec_i[1:0], bus.mepc_i[0]};

  // An ID exception loses to a coincident mret: EX is the older instruction.
  assign is_exc = bus.exc_ex_valid_i || (!bus.mret_ex_i && bus.exc_id_valid_i);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    count_inc = 1'b0;
    save_id   = 1'b0;
    save_ex   = 1'b0;
    cause     = 5'd0;
    fl_if     = 1'b0;
    fl_id     = 1'b0;
    fl_ex     = 1'b0;
`ifdef TRAP_LOCKUP_EN
    handler_d = handler_q;
`endif
    case (state_q)
      IDLE: begin
        if (is_exc) begin
          count_inc = 1'b1;
          fl_if     = 1'b1;
          fl_id     = 1'b1;
          fl_ex     = bus.exc_ex_valid_i;
`ifdef TRAP_LOCKUP_EN
          if (handler_q) begin
            // Nested trap: no save so the original mepc survives for debug.
            fl_ex   = 1'b1;
            state_d = LOCKUP;
          end else begin
            handler_d = 1'b1;
`endif
            save_ex = bus.exc_ex_valid_i;
            save_id = !bus.exc_ex_valid_i;
            cause   = bus.exc_ex_valid_i ? bus.exc_ex_cause_i : bus.exc_id_cause_i;
            addr_d  = {bus.mtvec_i[31:2], 2'b00};
            state_d = REDIRECT;
`ifdef TRAP_LOCKUP_EN
          end
`endif
        end else if (bus.mret_ex_i) begin
          fl_if   = 1'b1;
          fl_id   = 1'b1;
          addr_d  = {bus.mepc_i[31:1], 1'b0};
          state_d = REDIRECT;
`ifdef TRAP_LOCKUP_EN
          handler_d = 1'b0;
`endif
        end
      end
      REDIRECT: begin
        fl_if = 1'b1;
        if (bus.redirect_ready_i) state_d = IDLE;
      end
`ifdef TRAP_LOCKUP_EN
      LOCKUP: begin
        fl_if = 1'b1;
        fl_id = 1'b1;
        fl_ex = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (count_inc) count_q <= count_q + CNT_W'(1);
    end
  end

`ifdef TRAP_LOCKUP_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) handler_q <= 1'b0;
    else          handler_q <= handler_d;
  end
  assign bus.lockup_o = (state_q == LOCKUP);
`else
  assign bus.lockup_o = 1'b0;
`endif

  assign bus.save_pc_id_o      = save_id;
  assign bus.save_pc_ex_o      = save_ex;
  assign bus.exception_cause_o = cause;
  assign bus.flush_if_o        = fl_if;
  assign bus.flush_id_o        = fl_id;
  assign bus.flush_ex_o        = fl_ex;
  assign bus.redirect_valid_o  = (state_q == REDIRECT);
  assign bus.redirect_addr_o   = addr_q;
  assign bus.busy_o            = (state_q != IDLE);
  assign bus.trap_count_o      = count_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl: arbitration, redirect handshake, stall, async reset,
// nested traps (expectations follow TRAP_LOCKUP_EN) and counter wrap with a 4-bit counter.
module tb_trap_ctrl;
  localparam int CNT_W = 4;

  logic clk_i = 1'b0;
  logic rst_n_i;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk_i = ~clk_i;

  trap_ctrl_if #(.CNT_W(CNT_W)) bus ();
  trap_ctrl #(.CNT_W(CNT_W)) dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));

  // {save_id, save_ex, cause[4:0], flush_if, flush_id, flush_ex}
  function automatic logic [9:0] ctrl_obs();
    return {bus.save_pc_id_o, bus.save_pc_ex_o, bus.exception_cause_o,
            bus.flush_if_o, bus.flush_id_o, bus.flush_ex_o};
  endfunction

  function automatic logic [9:0] ctl(input logic sid, input logic sex, input logic [4:0] c,
                                     input logic fi, input logic fd, input logic fe);
    return {sid, sex, c, fi, fd, fe};
  endfunction

  // {redirect_valid, busy, lockup}
  function automatic logic [2:0] stat_obs();
    return {bus.redirect_valid_o, bus.busy_o, bus.lockup_o};
  endfunction

  task automatic clear_inputs(input logic ready);
    bus.exc_id_valid_i   = 1'b0;
    bus.exc_id_cause_i   = 5'd0;
    bus.exc_ex_valid_i   = 1'b0;
    bus.exc_ex_cause_i   = 5'd0;
    bus.mret_ex_i        = 1'b0;
    bus.mtvec_i          = 32'd0;
    bus.mepc_i           = 32'd0;
    bus.redirect_ready_i = ready;
  endtask

  task automatic do_mret();
    @(negedge clk_i);
    clear_inputs(1'b1);
    bus.mret_ex_i = 1'b1;
    bus.mepc_i    = 32'h0000_0040;
    @(negedge clk_i);
    clear_inputs(1'b1);
    @(negedge clk_i);
    clear_inputs(1'b0);
  endtask

  task automatic pulse_reset();
    #1 rst_n_i = 1'b0;
    clear_inputs(1'b0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b1;
    clear_inputs(1'b0);
    #1 rst_n_i = 1'b0;
    #2;
    tests_run++;
    if (ctrl_obs() !== 10'd0) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b want %b", ctrl_obs(), 10'd0);
    end
    tests_run++;
    if (stat_obs() !== 3'b000) begin
      tests_failed++; $display("FAIL reset_stat: got %b want 000", stat_obs());
    end
    tests_run++;
    if (bus.redirect_addr_o !== 32'd0 || bus.trap_count_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_addr_cnt: got addr %h cnt %0d want 0 0", bus.redirect_addr_o, bus.trap_count_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_id_exc();
    @(negedge clk_i);
    clear_inputs(1'b1);
    bus.exc_id_valid_i = 1'b1;
    bus.exc_id_cause_i = 5'd2;
    bus.mtvec_i        = 32'h0000_0100;
    #1;
    tests_run++;
    if (ctrl_obs() !== ctl(1, 0, 5'd2, 1, 1, 0) || stat_obs() !== 3'b000) begin
      tests_failed++;
      $display("FAIL id_exc_accept: got ctrl %b stat %b want %b 000", ctrl_obs(), stat_obs(), ctl(1, 0, 5'd2, 1, 1, 0));
    end
    @(negedge clk_i);
    clear_inputs(1'b1);
    #1;
    tests_run++;
    if (stat_obs() !== 3'b110 || bus.redirect_addr_o !== 32'h0000_0100) begin
      tests_failed++;
      $display("FAIL id_exc_redirect: got stat %b addr %h want 110 00000100", stat_obs(), bus.redirect_addr_o);
    end
    tests_run++;
    if (ctrl_obs() !== ctl(0, 0, 5'd0, 1, 0, 0) || bus.trap_count_o !== 4'd1) begin
      tests_failed++;
      $display("FAIL id_exc_flush_cnt: got ctrl %b cnt %0d want %b 1", ctrl_obs(), bus.trap_count_o, ctl(0, 0, 5'd0, 1, 0, 0));
    end
  endtask

  // Issued in the cycle right after the ID trap's redirect: minimum spacing.
  task automatic test_mret_back_to_back();
    @(negedge clk_i);
    clear_inputs(1'b1);
    bus.mret_ex_i      = 1'b1;
    bus.exc_id_valid_i = 1'b1;
    bus.exc_id_cause_i = 5'd5;
    bus.mepc_i         = 32'h0000_0203;
    #1;
    tests_run++;
    if (ctrl_obs() !== ctl(0, 0, 5'd0, 1, 1, 0) || stat_obs() !== 3'b000) begin
      tests_failed++;
      $display("FAIL mret_accept: got ctrl %b stat %b want %b 000", ctrl_obs(), stat_obs(), ctl(0, 0, 5'd0, 1, 1, 0));
    end
    @(negedge clk_i);
    clear_inputs(1'b1);
    #1;
    tests_run++;
    if (stat_obs() !== 3'b110 || bus.redirect_addr_o !== 32'h0000_0202 || bus.trap_count_o !== 4'd1) begin
      tests_failed++;
      $display("FAIL mret_redirect: got stat %b addr %h cnt %0d want 110 00000202 1",
               stat_obs(), bus.redirect_addr_o, bus.trap_count_o);
    end
    @(negedge clk_i);
    clear_inputs(1'b0);
    #1;
    tests_run++;
    if (stat_obs() !== 3'b000) begin
      tests_failed++; $display("FAIL mret_idle: got stat %b want 000", stat_obs());
    end
  endtask

  task automatic test_ex_over_id();
    @(negedge clk_i);
    clear_inputs(1'b1);
    bus.exc_ex_valid_i = 1'b1;
    bus.exc_ex_cause_i = 5'd3;
    bus.exc_id_valid_i = 1'b1;
    bus.exc_id_cause_i = 5'd2;
    bus.mtvec_i        = 32'h0000_0207;
    #1;
    tests_run++;
    if (ctrl_obs() !== ctl(0, 1, 5'd3, 1, 1, 1)) begin
      tests_failed++; $display("FAIL ex_over_id_ctrl: got %b want %b", ctrl_obs(), ctl(0, 1, 5'd3, 1, 1, 1));
    end
    @(negedge clk_i);
    clear_inputs(1'b1);
    #1;
    tests_run++;
    if (stat_obs() !== 3'b110 || bus.redirect_addr_o !== 32'h0000_0204 || bus.trap_count_o !== 4'd2) begin
      tests_failed++;
      $display("FAIL ex_over_id_redirect: got stat %b addr %h cnt %0d want 110 00000204 2",
               stat_obs(), bus.redirect_addr_o, bus.trap_count_o);
    end
    @(negedge clk_i);
    clear_inputs(1'b0);
    do_mret();
  endtask

  task automatic test_ready_stall();
    @(negedge clk_i);
    clear_inputs(1'b0);
    bus.exc_ex_valid_i = 1'b1;
    bus.exc_ex_cause_i = 5'd7;
    bus.mtvec_i        = 32'h0000_0300;
    #1;
    tests_run++;
    if (ctrl_obs() !== ctl(0, 1, 5'd7, 1, 1, 1)) begin
      tests_failed++; $display("FAIL stall_accept: got %b want %b", ctrl_obs(), ctl(0, 1, 5'd7, 1, 1, 1));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      bus.exc_ex_valid_i   = 1'b1;
      bus.exc_ex_cause_i   = 5'd9;
      bus.exc_id_valid_i   = 1'b1;
      bus.exc_id_cause_i   = 5'd4;
      bus.mret_ex_i        = 1'b1;
      bus.mtvec_i          = 32'h0000_0500;
      bus.mepc_i           = 32'h0000_0600;
      bus.redirect_ready_i = (i == 4);
      #1;
      tests_run++;
      if (stat_obs() !== 3'b110 || bus.redirect_addr_o !== 32'h0000_0300 ||
          ctrl_obs() !== ctl(0, 0, 5'd0, 1, 0, 0) || bus.trap_count_o !== 4'd3) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got stat %b addr %h ctrl %b cnt %0d want 110 00000300 %b 3",
                 i, stat_obs(), bus.redirect_addr_o, ctrl_obs(), bus.trap_count_o, ctl(0, 0, 5'd0, 1, 0, 0));
      end
    end
    @(negedge clk_i);
    clear_inputs(1'b0);
    #1;
    tests_run++;
    if (stat_obs() !== 3'b000 || bus.trap_count_o !== 4'd3) begin
      tests_failed++;
      $display("FAIL stall_release: got stat %b cnt %0d want 000 3", stat_obs(), bus.trap_count_o);
    end
    do_mret();
  endtask

  task automatic test_reset_mid_redirect();
    @(negedge clk_i);
    clear_inputs(1'b0);
    bus.exc_ex_valid_i = 1'b1;
    bus.exc_ex_cause_i = 5'd1;
    bus.mtvec_i        = 32'h0000_0400;
    @(negedge clk_i);
    clear_inputs(1'b0);
    #1;
    tests_run++;
    if (stat_obs() !== 3'b110 || bus.trap_count_o !== 4'd4) begin
      tests_failed++;
      $display("FAIL midreset_pre: got stat %b cnt %0d want 110 4", stat_obs(), bus.trap_count_o);
    end
    #1 rst_n_i = 1'b0;
    #1;
    tests_run++;
    if (stat_obs() !== 3'b000 || bus.redirect_addr_o !== 32'd0 ||
        bus.trap_count_o !== 4'd0 || ctrl_obs() !== 10'd0) begin
      tests_failed++;
      $display("FAIL midreset_async: got stat %b addr %h cnt %0d ctrl %b want 000 0 0 0",
               stat_obs(), bus.redirect_addr_o, bus.trap_count_o, ctrl_obs());
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_nested();
    @(negedge clk_i);
    clear_inputs(1'b1);
    bus.exc_ex_valid_i = 1'b1;
    bus.exc_ex_cause_i = 5'd4;
    bus.mtvec_i        = 32'h0000_0100;
    @(negedge clk_i);
    clear_inputs(1'b1);
    @(negedge clk_i);
    clear_inputs(1'b1);
    bus.exc_id_valid_i = 1'b1;
    bus.exc_id_cause_i = 5'd2;
    bus.mtvec_i        = 32'h0000_0180;
    #1;
    tests_run++;
`ifdef TRAP_LOCKUP_EN
    if (ctrl_obs() !== ctl(0, 0, 5'd0, 1, 1, 1)) begin
      tests_failed++; $display("FAIL nested_accept: got %b want %b", ctrl_obs(), ctl(0, 0, 5'd0, 1, 1, 1));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      clear_inputs(1'b1);
      bus.mret_ex_i      = (i != 0);
      bus.exc_ex_valid_i = (i != 0);
      #1;
      tests_run++;
      if (stat_obs() !== 3'b011 || ctrl_obs() !== ctl(0, 0, 5'd0, 1, 1, 1) || bus.trap_count_o !== 4'd2) begin
        tests_failed++;
        $display("FAIL nested_lockup[%0d]: got stat %b ctrl %b cnt %0d want 011 %b 2",
                 i, stat_obs(), ctrl_obs(), bus.trap_count_o, ctl(0, 0, 5'd0, 1, 1, 1));
      end
    end
`else
    if (ctrl_obs() !== ctl(1, 0, 5'd2, 1, 1, 0)) begin
      tests_failed++; $display("FAIL nested_accept: got %b want %b", ctrl_obs(), ctl(1, 0, 5'd2, 1, 1, 0));
    end
    @(negedge clk_i);
    clear_inputs(1'b1);
    #1;
    tests_run++;
    if (stat_obs() !== 3'b110 || bus.redirect_addr_o !== 32'h0000_0180 || bus.trap_count_o !== 4'd2) begin
      tests_failed++;
      $display("FAIL nested_redirect: got stat %b addr %h cnt %0d want 110 00000180 2",
               stat_obs(), bus.redirect_addr_o, bus.trap_count_o);
    end
`endif
    pulse_reset();
  endtask

  task automatic test_count_wrap();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      clear_inputs(1'b1);
      bus.exc_ex_valid_i = 1'b1;
      bus.exc_ex_cause_i = i[4:0];
      @(negedge clk_i);
      clear_inputs(1'b1);
      do_mret();
      if (i == 14) begin
        tests_run++;
        if (bus.trap_count_o !== 4'd15) begin
          tests_failed++; $display("FAIL count_max: got %0d want 15", bus.trap_count_o);
        end
      end
    end
    tests_run++;
    if (bus.trap_count_o !== 4'd0) begin
      tests_failed++; $display("FAIL count_wrap: got %0d want 0", bus.trap_count_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_id_exc();
    test_mret_back_to_back();
    test_ex_over_id();
    test_ready_stall();
    test_reset_mid_redirect();
    test_nested();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap and return sequencer that drives the trap side of the CSR file and redirects fetch. It arbitrates exception requests from ID and EX and `mret` from EX, and commands the CSR file to save PC and cause. It flushes the appropriate pipeline stages and holds a redirect to the trap vector or return address until fetch accepts it. It sits between the pipeline stages, the CSR file (`save_pc_*`, `exception_cause`, `mtvec`, `mepc`) and the IF stage.

## Interface
- `CNT_W`, 16: width of the trap event counter.
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `exc_id_valid_i`  in  1  exception request on the instruction in ID.
- `exc_id_cause_i`  in  5  cause code for the ID exception.
- `exc_ex_valid_i`  in  1  exception request on the instruction in EX.
- `exc_ex_cause_i`  in  5  cause code for the EX exception.
- `mret_ex_i`  in  1  valid `mret` in EX.
- `mtvec_i`  in  32  trap vector from the CSR file.
- `mepc_i`  in  32  next-value `mepc` from the CSR file.
- `save_pc_id_o`  out  1  CSR file saves ID PC and cause this cycle.
- `save_pc_ex_o`  out  1  CSR file saves EX PC and cause this cycle.
- `exception_cause_o`  out  5  cause code to the CSR file.
- `flush_if_o`, `flush_id_o`, `flush_ex_o`  out  1 each  stage kill.
- `redirect_valid_o`  out  1  fetch redirect request.
- `redirect_addr_o`  out  32  redirect target.
- `redirect_ready_i`  in  1  fetch accepts the redirect.
- `busy_o`  out  1  sequencer not in IDLE.
- `lockup_o`  out  1  core locked after a nested trap.
- `trap_count_o`  out  CNT_W  number of accepted traps.

## Operation
- FSM states: IDLE, REDIRECT, LOCKUP.
- Event acceptance happens only in IDLE. Priority is EX exception, then `mret`, then ID exception. EX is older than ID, so an ID exception that coincides with `mret` is discarded.
- EX exception:
  - `save_pc_ex_o`=1.
  - `exception_cause_o`=`exc_ex_cause_i`.
  - All three flushes are asserted.
  - Target is `{mtvec_i[31:2],2'b00}`.
- ID exception:
  - `save_pc_id_o`=1.
  - `exception_cause_o`=`exc_id_cause_i`.
  - `flush_if_o` and `flush_id_o` are asserted; `flush_ex_o`=0.
  - Target is the same as for an EX exception.
- `mret`:
  - No save.
  - `flush_if_o` and `flush_id_o` are asserted.
  - Target is `{mepc_i[31:1],1'b0}`.
- `save_pc_id_o` and `save_pc_ex_o` are never high together.
- `exception_cause_o` is 0 whenever no save is asserted.
- On acceptance, the FSM latches the target into `redirect_addr_o` and moves IDLE→REDIRECT.
- In REDIRECT:
  - `redirect_valid_o`=1 and `flush_if_o`=1.
  - Every request input is ignored.
  - `redirect_addr_o` is stable.
  - When `redirect_valid_o`&&`redirect_ready_i`, the FSM moves to IDLE.
- `trap_count_o` increments by 1 per accepted exception (not `mret`) and wraps modulo 2^CNT_W.
- `busy_o` = (state != IDLE).

## Timing
- Reset values:
  - state IDLE.
  - `redirect_valid_o`=0, `redirect_addr_o`=0.
  - `lockup_o`=0, `busy_o`=0.
  - `trap_count_o`=0.
  - Save, cause and flush outputs are all 0.
- Save, cause and flush outputs are combinational from the inputs in the acceptance cycle N. The CSR file updates `mepc`/`mcause` at the end of N.
- `redirect_valid_o` rises in N+1 and holds until the cycle in which ready is sampled high (inclusive). It falls in the next cycle.
- Minimum trap-to-trap spacing: acceptance N, redirect N+1 with ready=1, next acceptance N+2.
- `mepc_i` is the next value of `mepc`, so a CSR write to `mepc` in the same cycle as `mret` is honoured.
- A reset during REDIRECT drops the redirect immediately (asynchronous).

## Configuration
- `TRAP_LOCKUP_EN` defined:
  - An `in_handler` flag is set on exception acceptance and cleared on `mret` acceptance.
  - An exception accepted while `in_handler`=1 goes IDLE→LOCKUP.
  - That exception asserts all flushes and no save, so the original `mepc` is preserved. No redirect is issued and the counter still increments.
  - LOCKUP holds `lockup_o`=1, `busy_o`=1 and all flushes asserted, and ignores all inputs until reset.
- `TRAP_LOCKUP_EN` undefined:
  - No flag and no LOCKUP state.
  - Nested traps are handled like any other trap.
  - `lockup_o` is tied 0.

## Test plan
- ID exception, cause 2, `mtvec_i`=0x0000_0100, ready=1 → N: `save_pc_id_o`=1, cause=2, `flush_ex_o`=0; N+1: `redirect_valid_o`=1, addr=0x100; N+2: IDLE; count=1.
- EX exception (cause 3) and ID exception (cause 2) in the same cycle → only `save_pc_ex_o`=1, cause=3, all flushes asserted.
- `mret` with `mepc_i`=0x0000_0203 → no save, cause=0, addr=0x202.
- Ready held 0 for 4 cycles while exceptions keep arriving → `redirect_valid_o` and addr stable, no saves, count unchanged; FSM returns to IDLE one cycle after ready=1.
- `rst_n_i` low mid-REDIRECT → all outputs at reset values asynchronously.
- With `TRAP_LOCKUP_EN`, two exceptions without an intervening `mret` → second: no save, `lockup_o`=1 persists. Without the macro → second trap is saved and redirected normally.
